// File: rtl/operand_skew_feeder.sv
// Operand skew feeder: turns one SRAM row per beat into a per-lane staircase for the PE-array edge.
// Optional build macro SKEW_FEEDER_PERF_EN adds stall/bubble performance counters.
module operand_skew_feeder #(
    parameter int BWIDTH         = 8,
    parameter int NUM_LANES      = 32,
    parameter int NUM_LANES_LOG2 = 5
) (
    input  logic                          CLK,
    input  logic                          RSTn,
    input  logic                          STALL,
    input  logic                          MODE_in,
    input  logic [NUM_LANES_LOG2:0]       ACTIVE_LANES_in,
    input  logic                          VALID_in,
    input  logic                          LAST_in,
    input  logic [NUM_LANES*BWIDTH-1:0]   D_in,
    output logic                          READY_out,
    output logic [NUM_LANES*BWIDTH-1:0]   D_out,
    output logic [NUM_LANES-1:0]          VALID_out,
    output logic                          DONE_out
`ifdef SKEW_FEEDER_PERF_EN
    ,
    output logic [31:0]                   STALL_CNT_out,
    output logic [31:0]                   BUBBLE_CNT_out
`endif
);

    localparam int AW = NUM_LANES_LOG2 + 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [NUM_LANES_LOG2-1:0] CNT_LAST = NUM_LANES_LOG2'(NUM_LANES - 1);

    logic [1:0]                state_r;
    logic [NUM_LANES_LOG2-1:0] cnt_r;
    logic                      mode_r;
    logic [AW-1:0]             act_r;
    logic                      done_r;

    // Every lane owns a full-length chain whose last stage drives the output; the row is
    // written part-way along the chain so that its remaining distance equals the lane delay.
    logic [BWIDTH-1:0]    dat_r [NUM_LANES][NUM_LANES];
    logic [NUM_LANES-1:0] vld_r [NUM_LANES];

    logic                 ready_s;
    logic                 accept_s;
    logic                 eff_mode_s;
    logic [AW-1:0]        eff_act_s;
    logic [NUM_LANES-1:0] live_s;
    logic [BWIDTH-1:0]    in_dat_s [NUM_LANES];
    logic [NUM_LANES-1:0] load_s [NUM_LANES];

    // Handshake, effective job configuration, lane liveness and chain insertion points
    always_comb begin
        ready_s  = ~STALL & (state_r != S_DRAIN);
        accept_s = VALID_in & ready_s;
        if (state_r == S_IDLE) begin
            eff_mode_s = MODE_in;
            eff_act_s  = ACTIVE_LANES_in;
        end else begin
            eff_mode_s = mode_r;
            eff_act_s  = act_r;
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            live_s[i]   = (eff_act_s == {AW{1'b0}}) || (AW'(i) < eff_act_s);
            in_dat_s[i] = live_s[i] ? D_in[i*BWIDTH +: BWIDTH] : {BWIDTH{1'b0}};
            for (int j = 0; j < NUM_LANES; j++) begin
                load_s[i][j] = accept_s && (j == (eff_mode_s ? i : NUM_LANES - 1 - i));
            end
        end
    end

    // Delay chains: shift every non-stalled cycle, bubbles enter at stage 0
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                vld_r[i] <= {NUM_LANES{1'b0}};
                for (int j = 0; j < NUM_LANES; j++) begin
                    dat_r[i][j] <= {BWIDTH{1'b0}};
                end
            end
        end else if (!STALL) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                dat_r[i][0] <= load_s[i][0] ? in_dat_s[i] : {BWIDTH{1'b0}};
                vld_r[i][0] <= load_s[i][0] & live_s[i];
                for (int j = 1; j < NUM_LANES; j++) begin
                    dat_r[i][j] <= load_s[i][j] ? in_dat_s[i] : dat_r[i][j-1];
                    vld_r[i][j] <= load_s[i][j] ? live_s[i] : vld_r[i][j-1];
                end
            end
        end
    end

    // Job FSM, drain counter and DONE pulse
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_r <= S_IDLE;
            cnt_r   <= {NUM_LANES_LOG2{1'b0}};
            mode_r  <= 1'b0;
            act_r   <= {AW{1'b0}};
            done_r  <= 1'b0;
        end else if (!STALL) begin
            done_r <= (state_r == S_DRAIN) && (cnt_r == CNT_LAST);
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        state_r <= LAST_in ? S_DRAIN : S_RUN;
                        mode_r  <= MODE_in;
                        act_r   <= ACTIVE_LANES_in;
                    end
                end
                S_RUN: begin
                    if (accept_s && LAST_in) begin
                        state_r <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r <= S_IDLE;
                        cnt_r   <= {NUM_LANES_LOG2{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + {{(NUM_LANES_LOG2-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    cnt_r   <= {NUM_LANES_LOG2{1'b0}};
                end
            endcase
        end
    end

    // Outputs come straight from the final chain stages
    always_comb begin
        D_out     = {(NUM_LANES*BWIDTH){1'b0}};
        VALID_out = {NUM_LANES{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            D_out[i*BWIDTH +: BWIDTH] = dat_r[i][NUM_LANES-1];
            VALID_out[i]              = vld_r[i][NUM_LANES-1];
        end
    end

    assign READY_out = ready_s;
    assign DONE_out  = done_r;

`ifdef SKEW_FEEDER_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] bubble_cnt_r;

    // Saturating stall and bubble counters, cleared at job start
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            stall_cnt_r  <= 32'd0;
            bubble_cnt_r <= 32'd0;
        end else if (accept_s && (state_r == S_IDLE)) begin
            stall_cnt_r  <= 32'd0;
            bubble_cnt_r <= 32'd0;
        end else begin
            if (STALL && (state_r != S_IDLE) && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (!STALL && !VALID_in && (state_r == S_RUN) && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
                bubble_cnt_r <= bubble_cnt_r + 32'd1;
            end
        end
    end

    assign STALL_CNT_out  = stall_cnt_r;
    assign BUBBLE_CNT_out = bubble_cnt_r;
`endif

endmodule
